// File: rtl/axi_read_arbiter.sv
//------------------------------------------------------------------------------
// Module      : axi_read_arbiter
// Description : Two-to-one single-beat AXI read arbiter (instruction/data ports)
//               serialising reads onto one memory master, one outstanding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int D_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_i_arvalid,
    output logic                  s_i_arready,
    input  logic [ADDR_WIDTH-1:0] s_i_araddr,
    output logic                  s_i_rvalid,
    input  logic                  s_i_rready,
    output logic [DATA_WIDTH-1:0] s_i_rdata,
    output logic [1:0]            s_i_rresp,
    output logic                  s_i_rlast,
    input  logic                  s_d_arvalid,
    output logic                  s_d_arready,
    input  logic [ADDR_WIDTH-1:0] s_d_araddr,
    output logic                  s_d_rvalid,
    input  logic                  s_d_rready,
    output logic [DATA_WIDTH-1:0] s_d_rdata,
    output logic [1:0]            s_d_rresp,
    output logic                  s_d_rlast,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic c_DPRIO = (D_PRIORITY != 0);

    state_t                  r_state;
    logic                    r_grant;       // 1 = data port
    logic                    r_last_grant;  // 1 = data port
    logic [ADDR_WIDTH-1:0]   r_addr_q;
    logic [DATA_WIDTH-1:0]   r_rdata_q;
    logic [1:0]              r_rresp_q;
    logic                    r_rlast_q;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_i_rvalid;
    logic                    r_d_rvalid;

    logic                    w_pick_d;
    logic                    w_ar_fire;
    logic                    w_s_rready;

    // On a tie the port that did not win last time goes next, unless the
    // data port is configured to always win.
    always_comb begin
        w_pick_d = 1'b0;
        if (s_d_arvalid && !s_i_arvalid) begin
            w_pick_d = 1'b1;
        end else if (s_d_arvalid && s_i_arvalid) begin
            w_pick_d = c_DPRIO || !r_last_grant;
        end
    end

    assign s_i_arready = (r_state == IDLE) && s_i_arvalid && !w_pick_d;
    assign s_d_arready = (r_state == IDLE) && s_d_arvalid &&  w_pick_d;
    assign w_ar_fire   = s_i_arready || s_d_arready;
    assign w_s_rready  = r_grant ? s_d_rready : s_i_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr_q     <= '0;
            r_rdata_q    <= '0;
            r_rresp_q    <= 2'b00;
            r_rlast_q    <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_i_rvalid   <= 1'b0;
            r_d_rvalid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ar_fire) begin
                        r_grant   <= w_pick_d;
                        r_addr_q  <= w_pick_d ? s_d_araddr : s_i_araddr;
                        r_arvalid <= 1'b1;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (m_rvalid) begin
                        r_rdata_q  <= m_rdata;
                        r_rresp_q  <= m_rresp;
                        r_rlast_q  <= m_rlast;
                        r_rready   <= 1'b0;
                        r_i_rvalid <= !r_grant;
                        r_d_rvalid <= r_grant;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (w_s_rready) begin
                        r_i_rvalid   <= 1'b0;
                        r_d_rvalid   <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_arvalid  = r_arvalid;
    assign m_araddr   = r_addr_q;
    assign m_rready   = r_rready;

    // Response payload is shared; only the granted port's rvalid qualifies it.
    assign s_i_rvalid = r_i_rvalid;
    assign s_i_rdata  = r_rdata_q;
    assign s_i_rresp  = r_rresp_q;
    assign s_i_rlast  = r_rlast_q;
    assign s_d_rvalid = r_d_rvalid;
    assign s_d_rdata  = r_rdata_q;
    assign s_d_rresp  = r_rresp_q;
    assign s_d_rlast  = r_rlast_q;

endmodule

`default_nettype wire
